// File: rtl/data_ram_arb_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
//   port_e     : identifies one of the two requesters (LSU = PORT0, AXI bridge = PORT1)
//   PRIO_*     : values for the top-level PRIO_MODE parameter
//   port_mask(): one-hot request/grant mask for a port
package data_ram_arb_pkg;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam int unsigned NUM_PORTS  = 2;
    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    // One-hot mask with bit N set for port N.
    function automatic logic [NUM_PORTS-1:0] port_mask(input port_e p);
        return (p == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_arb.sv
// Two-requester arbitration core. Purely combinational: the caller owns
// the round-robin pointer flop and feeds next_ptr back into it.
//   req[1:0]  in   request per port (bit N = port N)
//   ptr       in   current round-robin favourite
//   mode      in   1 = fixed priority to port 0, 0 = round-robin
//   gnt[1:0]  out  one-hot grant, or 0 when nothing requests
//   next_ptr  out  pointer value for the next cycle
module arb_rr_2
    import data_ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      ptr,
    input  logic       mode,
    output logic [1:0] gnt,
    output port_e      next_ptr
);

    // Only a genuine conflict moves the pointer; it then points at the loser
    // so the loser wins the next conflict.
    always_comb begin
        gnt      = 2'b00;
        next_ptr = ptr;
        case (req)
            2'b01: gnt = port_mask(PORT0);
            2'b10: gnt = port_mask(PORT1);
            2'b11: begin
                if (mode || (ptr == PORT0)) begin
                    gnt      = port_mask(PORT0);
                    next_ptr = PORT1;
                end else begin
                    gnt      = port_mask(PORT1);
                    next_ptr = PORT0;
                end
            end
            default: begin
                gnt      = 2'b00;
                next_ptr = ptr;
            end
        endcase
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Merges the LSU port (P0) and the AXI-to-mem bridge port (P1) onto the single
// port of the data RAM wrapper. Grants are combinational in the request cycle;
// the RAM answers one cycle later and the response is steered back to the
// port that owned the access. Per-port saturating stall counters are kept for
// performance debug.
// Ports:
//   clk, rst_i                      clock, synchronous active-high reset
//   pN_req_i / pN_gnt_o             request held until granted / same-cycle grant
//   pN_addr_i, pN_we_i, pN_be_i,
//   pN_wdata_i                      access payload of port N
//   pN_rvalid_o, pN_rdata_o         response one cycle after grant (rdata 0 for writes)
//   pN_stall_cnt_o                  cycles with request pending but not granted
//   ram_en_o .. ram_wdata_o         muxed access towards the RAM wrapper
//   ram_rdata_i                     RAM read data, valid one cycle after ram_en_o
//   bypass_en_i / ram_bypass_en_o   test bypass, passed straight through
module data_ram_arbiter
    import data_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PRIO_MODE  = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_i,

    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    output logic [CNT_WIDTH-1:0]    p0_stall_cnt_o,

    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    output logic [CNT_WIDTH-1:0]    p1_stall_cnt_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

    input  logic                    bypass_en_i,
    output logic                    ram_bypass_en_o
);

    localparam logic FIXED_PRIO = (PRIO_MODE == PRIO_FIXED);

    port_e                 rr_ptr_q;
    port_e                 rr_ptr_d;
    logic [1:0]            req;
    logic [1:0]            gnt;
    port_e                 winner;

    logic                  rvalid_q;
    port_e                 resp_port_q;
    logic                  resp_we_q;

    logic [CNT_WIDTH-1:0]  p0_stall_q;
    logic [CNT_WIDTH-1:0]  p1_stall_q;

    // Arbitration core
    assign req = {p1_req_i, p0_req_i};

    arb_rr_2 u_arb (
        .req      (req),
        .ptr      (rr_ptr_q),
        .mode     (FIXED_PRIO),
        .gnt      (gnt),
        .next_ptr (rr_ptr_d)
    );

    assign p0_gnt_o = gnt[0];
    assign p1_gnt_o = gnt[1];
    assign winner   = gnt[1] ? PORT1 : PORT0;

    // RAM request mux; an idle cycle drives an all-zero request
    always_comb begin
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (gnt[0]) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = p0_addr_i;
            ram_we_o    = p0_we_i;
            ram_be_o    = p0_be_i;
            ram_wdata_o = p0_wdata_i;
        end else if (gnt[1]) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = p1_addr_i;
            ram_we_o    = p1_we_i;
            ram_be_o    = p1_be_i;
            ram_wdata_o = p1_wdata_i;
        end
    end

    assign ram_bypass_en_o = bypass_en_i;

    // Round-robin pointer and response pipeline; reset drops any in-flight response
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rr_ptr_q    <= PORT0;
            rvalid_q    <= 1'b0;
            resp_port_q <= PORT0;
            resp_we_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rvalid_q    <= ram_en_o;
            resp_port_q <= winner;
            resp_we_q   <= ram_we_o;
        end
    end

    // Response steering; write responses carry no data
    always_comb begin
        p0_rvalid_o = rvalid_q && (resp_port_q == PORT0);
        p1_rvalid_o = rvalid_q && (resp_port_q == PORT1);
        p0_rdata_o  = (p0_rvalid_o && !resp_we_q) ? ram_rdata_i : '0;
        p1_rdata_o  = (p1_rvalid_o && !resp_we_q) ? ram_rdata_i : '0;
    end

    // Saturating stall counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst_i) begin
            p0_stall_q <= '0;
            p1_stall_q <= '0;
        end else begin
            if (p0_req_i && !gnt[0] && (p0_stall_q != '1)) begin
                p0_stall_q <= p0_stall_q + CNT_WIDTH'(1);
            end
            if (p1_req_i && !gnt[1] && (p1_stall_q != '1)) begin
                p1_stall_q <= p1_stall_q + CNT_WIDTH'(1);
            end
        end
    end

    assign p0_stall_cnt_o = p0_stall_q;
    assign p1_stall_cnt_o = p1_stall_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboarded bench for data_ram_arbiter. dut is the default round-robin
// build backed by a small RAM model; dut_f (fixed priority, 4-bit counters)
// shares the same request inputs and is checked for grants and stall counts.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        bypass_en;

    logic        p0_req, p1_req;
    logic [13:0] p0_addr, p1_addr;
    logic        p0_we, p1_we;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_wdata, p1_wdata;

    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [15:0] p0_stall, p1_stall;
    logic        ram_en, ram_we, ram_byp;
    logic [13:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    logic        f_p0_gnt, f_p1_gnt, f_p0_rvalid, f_p1_rvalid;
    logic [31:0] f_p0_rdata, f_p1_rdata;
    logic [3:0]  f_p0_stall, f_p1_stall;
    logic        f_ram_en, f_ram_we, f_ram_byp;
    logic [13:0] f_ram_addr;
    logic [3:0]  f_ram_be;
    logic [31:0] f_ram_wdata;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] mon_e0, mon_e1;

    always #5 clk = ~clk;

    data_ram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .PRIO_MODE(0), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_i(rst_i),
        .p0_req_i(p0_req), .p0_gnt_o(p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
        .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p0_stall_cnt_o(p0_stall),
        .p1_req_i(p1_req), .p1_gnt_o(p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
        .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .p1_stall_cnt_o(p1_stall),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .bypass_en_i(bypass_en), .ram_bypass_en_o(ram_byp)
    );

    data_ram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .PRIO_MODE(1), .CNT_WIDTH(4)) dut_f (
        .clk(clk), .rst_i(rst_i),
        .p0_req_i(p0_req), .p0_gnt_o(f_p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
        .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(f_p0_rvalid), .p0_rdata_o(f_p0_rdata),
        .p0_stall_cnt_o(f_p0_stall),
        .p1_req_i(p1_req), .p1_gnt_o(f_p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
        .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(f_p1_rvalid), .p1_rdata_o(f_p1_rdata),
        .p1_stall_cnt_o(f_p1_stall),
        .ram_en_o(f_ram_en), .ram_addr_o(f_ram_addr), .ram_we_o(f_ram_we), .ram_be_o(f_ram_be),
        .ram_wdata_o(f_ram_wdata), .ram_rdata_i(32'h0),
        .bypass_en_i(bypass_en), .ram_bypass_en_o(f_ram_byp)
    );

    // RAM model: 64 words, words 4 (0x10) and 12 (0x30) have preset contents
    logic [31:0] mem [0:63];
    logic [63:0] wr_mask = '0;
    logic [5:0]  ram_idx;
    logic [31:0] cur_word;

    function automatic logic [31:0] init_word(input logic [5:0] i);
        case (i)
            6'd4:    return 32'hDEADBEEF;
            6'd12:   return 32'hFFFF0000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    assign ram_idx  = ram_addr[7:2];
    assign cur_word = wr_mask[ram_idx] ? mem[ram_idx] : init_word(ram_idx);

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_idx]     <= merge(cur_word, ram_wdata, ram_be);
                wr_mask[ram_idx] <= 1'b1;
            end else begin
                ram_rdata <= cur_word;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every response is matched against the scoreboard queue of its port
    always @(negedge clk) begin
        if (p0_rvalid) begin
            if (q0.size() == 0) chk("p0 rvalid without grant", 32'(p0_rvalid), 32'd0);
            else begin
                mon_e0 = q0.pop_front();
                chk("p0 rdata", p0_rdata, mon_e0);
            end
        end else chk("p0 rdata idle", p0_rdata, 32'd0);
        if (p1_rvalid) begin
            if (q1.size() == 0) chk("p1 rvalid without grant", 32'(p1_rvalid), 32'd0);
            else begin
                mon_e1 = q1.pop_front();
                chk("p1 rdata", p1_rdata, mon_e1);
            end
        end else chk("p1 rdata idle", p1_rdata, 32'd0);
    end

    // One cycle: entered and left 1 time unit after a rising edge.
    // eg/eg2 = expected {p1,p0} grants of dut/dut_f, ed = expected response data.
    task automatic step(input logic rst, input logic r0, input logic r1, input logic [1:0] eg,
                        input logic [31:0] ed, input logic [1:0] eg2, input string tag);
        rst_i  = rst;
        p0_req = r0;
        p1_req = r1;
        @(negedge clk);
        chk({tag, " gnt"}, 32'({p1_gnt, p0_gnt}), 32'(eg));
        chk({tag, " fixed gnt"}, 32'({f_p1_gnt, f_p0_gnt}), 32'(eg2));
        if (!rst) begin
            if (eg[0]) q0.push_back(ed);
            if (eg[1]) q1.push_back(ed);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, "idle");
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 2'b00, "reset");
    endtask

    // n back-to-back conflicts starting with the round-robin pointer at P0
    task automatic dual(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b1, 1'b1, 2'b01, 32'hDEADBEEF, 2'b01, tag);
            else            step(1'b0, 1'b1, 1'b1, 2'b10, 32'hFFFFA5A5, 2'b01, tag);
        end
    endtask

    initial begin
        rst_i = 1'b1; bypass_en = 1'b0;
        p0_req = 1'b0; p0_addr = '0; p0_we = 1'b0; p0_be = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_addr = '0; p1_we = 1'b0; p1_be = '0; p1_wdata = '0;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("reset p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("reset p0_stall", 32'(p0_stall), 32'd0);
        chk("reset p1_stall", 32'(p1_stall), 32'd0);
        chk("reset fixed p1_stall", 32'(f_p1_stall), 32'd0);
        chk("reset ram_en", 32'(ram_en), 32'd0);

        // Single read by P0
        p0_addr = 14'h10; p0_we = 1'b0; p0_be = 4'hF;
        step(1'b0, 1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 2'b01, "rd0");
        chk("rd0 ram_addr", 32'(ram_addr), 32'h10);
        chk("rd0 ram_we", 32'(ram_we), 32'd0);
        chk("rd0 p1_rvalid", 32'(p1_rvalid), 32'd0);
        idle();
        chk("idle ram_en", 32'(ram_en), 32'd0);
        chk("idle ram_addr", 32'(ram_addr), 32'd0);
        chk("idle ram_be", 32'(ram_be), 32'd0);
        chk("idle ram_wdata", 32'(ram_wdata), 32'd0);

        // P1 partial write, then read back
        p1_addr = 14'h30; p1_we = 1'b1; p1_be = 4'b0011; p1_wdata = 32'hA5A5A5A5;
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 2'b10, "wr1");
        chk("wr1 ram_we", 32'(ram_we), 32'd1);
        chk("wr1 ram_be", 32'(ram_be), 32'h3);
        chk("wr1 ram_wdata", ram_wdata, 32'hA5A5A5A5);
        chk("wr1 ram_addr", 32'(ram_addr), 32'h30);
        p1_we = 1'b0; p1_be = 4'hF; p1_wdata = '0;
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'hFFFFA5A5, 2'b10, "rd1");
        idle();

        // Round-robin contention: 6 cycles from reset
        do_reset();
        dual(6, "rr");
        idle();
        chk("rr p0_stall", 32'(p0_stall), 32'd3);
        chk("rr p1_stall", 32'(p1_stall), 32'd3);
        chk("rr fixed p0_stall", 32'(f_p0_stall), 32'd0);
        chk("rr fixed p1_stall", 32'(f_p1_stall), 32'd6);

        // Fixed priority: 5 conflicts, then P1 alone
        do_reset();
        dual(5, "fx");
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'hFFFFA5A5, 2'b10, "fx p1 alone");
        chk("fx fixed p1_stall", 32'(f_p1_stall), 32'd5);
        chk("fx p1_stall", 32'(p1_stall), 32'd3);
        idle();

        // Saturation of the 4-bit counter
        do_reset();
        dual(20, "sat");
        idle();
        chk("sat fixed p1_stall", 32'(f_p1_stall), 32'd15);
        chk("sat p0_stall", 32'(p0_stall), 32'd10);
        chk("sat p1_stall", 32'(p1_stall), 32'd10);

        // Reset mid-operation: pointer moved to P1, reset drops the in-flight access
        step(1'b0, 1'b1, 1'b1, 2'b01, 32'hDEADBEEF, 2'b01, "pre");
        step(1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 2'b10, "rst mid");
        chk("rst mid p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("rst mid p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rst mid p0_stall", 32'(p0_stall), 32'd0);
        chk("rst mid p1_stall", 32'(p1_stall), 32'd0);
        step(1'b0, 1'b1, 1'b1, 2'b01, 32'hDEADBEEF, 2'b01, "post rst");
        idle();

        // Bypass is passed through without touching arbitration
        bypass_en = 1'b1;
        #1;
        chk("bypass on", 32'(ram_byp), 32'd1);
        step(1'b0, 1'b1, 1'b1, 2'b10, 32'hFFFFA5A5, 2'b01, "byp");
        step(1'b0, 1'b1, 1'b1, 2'b01, 32'hDEADBEEF, 2'b01, "byp");
        bypass_en = 1'b0;
        #1;
        chk("bypass off", 32'(ram_byp), 32'd0);
        idle();
        idle();

        chk("p0 responses outstanding", 32'(q0.size()), 32'd0);
        chk("p1 responses outstanding", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
